// File: rtl/dut_err_monitor.sv
// Error monitor: counts data/state error pulses, timestamps them relative to arm,
// and queues per-cycle error records in a small FIFO for a downstream consumer.
module dut_err_monitor #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned TS_W  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              arm_i,
    input  logic              clr_i,
    input  logic              err_data_i,
    input  logic              err_state_i,
    output logic              rec_valid_o,
    input  logic              rec_ready_i,
    output logic [TS_W-1:0]   rec_ts_o,
    output logic [1:0]        rec_type_o,
    output logic [CNT_W-1:0]  data_cnt_o,
    output logic [CNT_W-1:0]  state_cnt_o,
    output logic [TS_W-1:0]   first_ts_o,
    output logic [1:0]        state_o,
    output logic              ovf_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_FAULT = 2'b10
    } state_e;

    typedef struct packed {
        logic [TS_W-1:0] ts;
        logic [1:0]      typ;
    } rec_t;

    state_e             state_q;
    logic [TS_W-1:0]    ts_q;
    logic [TS_W-1:0]    first_ts_q;
    logic [CNT_W-1:0]   data_cnt_q;
    logic [CNT_W-1:0]   state_cnt_q;
    logic               ovf_q;
    rec_t               mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [OCC_W-1:0]   occ_q;
    logic               rec_valid_q;
    rec_t               head_q;

    logic               active;
    logic               any_err;
    logic               push_req;
    logic               pop;
    logic               full;
    logic               push;
    logic               drop;
    logic [PTR_W-1:0]   rd_ptr_d;
    logic [OCC_W-1:0]   occ_d;
    logic [OCC_W-1:0]   remain;
    rec_t               new_rec;
    rec_t               head_d;

    // FIFO bookkeeping; the head register always mirrors the oldest entry
    always_comb begin
        active   = (state_q != S_IDLE);
        any_err  = err_data_i | err_state_i;
        push_req = active & any_err;
        pop      = rec_valid_q & rec_ready_i;
        full     = (occ_q == OCC_W'(DEPTH));
        push     = push_req & (~full | pop);
        drop     = push_req & full & ~pop;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        occ_d    = occ_q + OCC_W'(push) - OCC_W'(pop);
        remain   = occ_q - OCC_W'(pop);
        new_rec  = '{ts: ts_q, typ: {err_state_i, err_data_i}};
        head_d   = head_q;
        if (remain != '0) begin
            head_d = mem_q[rd_ptr_d];
        end else if (push) begin
            head_d = new_rec;
        end
    end

    // Record storage needs no reset: entries are only read once written
    always_ff @(posedge clk_i) begin
        if (!clr_i && push) begin
            mem_q[wr_ptr_q] <= new_rec;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            ts_q        <= '0;
            first_ts_q  <= '0;
            data_cnt_q  <= '0;
            state_cnt_q <= '0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            rec_valid_q <= 1'b0;
            head_q      <= '0;
        end else if (clr_i) begin
            state_q     <= S_IDLE;
            ts_q        <= '0;
            first_ts_q  <= '0;
            data_cnt_q  <= '0;
            state_cnt_q <= '0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            rec_valid_q <= 1'b0;
            head_q      <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (arm_i) begin
                        state_q <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (any_err) begin
                        state_q    <= S_FAULT;
                        first_ts_q <= ts_q;
                    end
                end
                S_FAULT: state_q <= S_FAULT;
                default: state_q <= S_IDLE;
            endcase

            ts_q <= active ? ts_q + TS_W'(1) : '0;

            // Saturating totals, counted even when the record itself is dropped
            if (active && err_data_i && (data_cnt_q != '1)) begin
                data_cnt_q <= data_cnt_q + CNT_W'(1);
            end
            if (active && err_state_i && (state_cnt_q != '1)) begin
                state_cnt_q <= state_cnt_q + CNT_W'(1);
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end

            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            rec_valid_q <= (occ_d != '0);
            head_q      <= head_d;
        end
    end

    assign rec_valid_o = rec_valid_q;
    assign rec_ts_o    = head_q.ts;
    assign rec_type_o  = head_q.typ;
    assign data_cnt_o  = data_cnt_q;
    assign state_cnt_o = state_cnt_q;
    assign first_ts_o  = first_ts_q;
    assign state_o     = state_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_dut_err_monitor.sv
// Bench for dut_err_monitor: directed scenarios plus randomized traffic, all
// outputs compared each cycle against a queue-based reference model.
module tb_dut_err_monitor;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned TS_W  = 8;
    localparam int unsigned DEPTH = 4;
    localparam int          CMAX  = (1 << CNT_W) - 1;
    localparam int          TMOD  = (1 << TS_W);

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b1;
    logic             arm_i = 1'b0;
    logic             clr_i = 1'b0;
    logic             err_data_i = 1'b0;
    logic             err_state_i = 1'b0;
    logic             rec_ready_i = 1'b0;
    logic             rec_valid_o;
    logic [TS_W-1:0]  rec_ts_o;
    logic [1:0]       rec_type_o;
    logic [CNT_W-1:0] data_cnt_o;
    logic [CNT_W-1:0] state_cnt_o;
    logic [TS_W-1:0]  first_ts_o;
    logic [1:0]       state_o;
    logic             ovf_o;

    dut_err_monitor #(.CNT_W(CNT_W), .TS_W(TS_W), .DEPTH(DEPTH)) u_dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .arm_i       (arm_i),
        .clr_i       (clr_i),
        .err_data_i  (err_data_i),
        .err_state_i (err_state_i),
        .rec_valid_o (rec_valid_o),
        .rec_ready_i (rec_ready_i),
        .rec_ts_o    (rec_ts_o),
        .rec_type_o  (rec_type_o),
        .data_cnt_o  (data_cnt_o),
        .state_cnt_o (state_cnt_o),
        .first_ts_o  (first_ts_o),
        .state_o     (state_o),
        .ovf_o       (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: 0 idle, 1 armed, 2 fault; records held in queues
    int m_state, m_ts, m_first, m_dc, m_sc;
    int m_ovf;
    int q_ts[$];
    int q_ty[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_ts = 0; m_first = 0; m_dc = 0; m_sc = 0; m_ovf = 0;
        q_ts.delete();
        q_ty.delete();
    endtask

    task automatic model_clock(input bit a, input bit c, input bit ed, input bit es, input bit rdy);
        bit act;
        if (c) begin
            model_reset();
        end else begin
            act = (m_state != 0);
            if (q_ts.size() > 0 && rdy) begin
                void'(q_ts.pop_front());
                void'(q_ty.pop_front());
            end
            if (act && (ed || es)) begin
                if (q_ts.size() < DEPTH) begin
                    q_ts.push_back(m_ts);
                    q_ty.push_back(2 * int'(es) + int'(ed));
                end else begin
                    m_ovf = 1;
                end
                if (ed && m_dc < CMAX) m_dc++;
                if (es && m_sc < CMAX) m_sc++;
            end
            if (m_state == 0 && a) begin
                m_state = 1;
            end else if (m_state == 1 && (ed || es)) begin
                m_state = 2;
                m_first = m_ts;
            end
            m_ts = act ? (m_ts + 1) % TMOD : 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"},    32'(state_o),     32'(m_state));
        chk({tag, ".first_ts"}, 32'(first_ts_o),  32'(m_first));
        chk({tag, ".data_cnt"}, 32'(data_cnt_o),  32'(m_dc));
        chk({tag, ".state_cnt"},32'(state_cnt_o), 32'(m_sc));
        chk({tag, ".ovf"},      32'(ovf_o),       32'(m_ovf));
        chk({tag, ".valid"},    32'(rec_valid_o), 32'(q_ts.size() > 0));
        if (q_ts.size() > 0) begin
            chk({tag, ".rec_ts"},   32'(rec_ts_o),   32'(q_ts[0]));
            chk({tag, ".rec_type"}, 32'(rec_type_o), 32'(q_ty[0]));
        end
    endtask

    task automatic step(input string tag, input bit a, input bit c, input bit ed, input bit es, input bit rdy);
        arm_i = a; clr_i = c; err_data_i = ed; err_state_i = es; rec_ready_i = rdy;
        model_clock(a, c, ed, es, rdy);
        @(posedge clk_i);
        #1;
        check_all(tag);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".state"},    32'(state_o),     32'd0);
        chk({tag, ".first_ts"}, 32'(first_ts_o),  32'd0);
        chk({tag, ".data_cnt"}, 32'(data_cnt_o),  32'd0);
        chk({tag, ".state_cnt"},32'(state_cnt_o), 32'd0);
        chk({tag, ".ovf"},      32'(ovf_o),       32'd0);
        chk({tag, ".valid"},    32'(rec_valid_o), 32'd0);
        chk({tag, ".rec_ts"},   32'(rec_ts_o),    32'd0);
        chk({tag, ".rec_type"}, 32'(rec_type_o),  32'd0);
    endtask

    initial begin
        model_reset();
        #2 rst_ni = 1'b0;
        #1 check_reset_values("por");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Arm, data error at timestamp 10
        step("arm", 1, 0, 0, 0, 0);
        repeat (10) step("wait10", 0, 0, 0, 0, 0);
        step("err10", 0, 0, 1, 0, 0);
        chk("t34.state", 32'(state_o), 32'd2);
        chk("t34.first_ts", 32'(first_ts_o), 32'd10);
        chk("t34.rec_ts", 32'(rec_ts_o), 32'd10);
        chk("t34.rec_type", 32'(rec_type_o), 32'd1);
        chk("t34.data_cnt", 32'(data_cnt_o), 32'd1);

        // Both errors in the same cycle give one record of type 3
        step("clr", 0, 1, 0, 0, 0);
        step("arm", 1, 0, 0, 0, 0);
        repeat (5) step("wait5", 0, 0, 0, 0, 0);
        step("both", 0, 0, 1, 1, 0);
        chk("t35.rec_type", 32'(rec_type_o), 32'd3);
        chk("t35.rec_ts", 32'(rec_ts_o), 32'd5);
        chk("t35.data_cnt", 32'(data_cnt_o), 32'd1);
        chk("t35.state_cnt", 32'(state_cnt_o), 32'd1);
        step("one_pop", 0, 0, 0, 0, 1);
        chk("t35.drained", 32'(rec_valid_o), 32'd0);

        // Overflow with a stalled consumer, then drain
        step("clr", 0, 1, 0, 0, 0);
        step("arm", 1, 0, 0, 0, 0);
        repeat (DEPTH + 1) step("fill", 0, 0, 1, 0, 0);
        chk("t36.ovf", 32'(ovf_o), 32'd1);
        chk("t36.data_cnt", 32'(data_cnt_o), 32'(DEPTH + 1));
        chk("t36.head_ts", 32'(rec_ts_o), 32'd0);
        repeat (DEPTH) step("drain", 0, 0, 0, 0, 1);
        chk("t36.empty", 32'(rec_valid_o), 32'd0);
        chk("t36.ovf_sticky", 32'(ovf_o), 32'd1);

        // Full FIFO with simultaneous push and pop
        step("clr", 0, 1, 0, 0, 0);
        step("arm", 1, 0, 0, 0, 0);
        repeat (DEPTH) step("fill", 0, 0, 1, 0, 0);
        step("pushpop", 0, 0, 1, 0, 1);
        chk("t37.ovf", 32'(ovf_o), 32'd0);
        chk("t37.head_ts", 32'(rec_ts_o), 32'd1);
        repeat (DEPTH) step("drain", 0, 0, 0, 0, 1);
        chk("t37.last_gone", 32'(rec_valid_o), 32'd0);

        // State counter saturation
        step("clr", 0, 1, 0, 0, 0);
        step("arm", 1, 0, 0, 0, 0);
        repeat (20) step("sat", 0, 0, 0, 1, 1);
        chk("t38.state_cnt", 32'(state_cnt_o), 32'd15);

        // Clear wins over a same-cycle error; idle ignores errors
        step("clr_err", 0, 1, 1, 1, 0);
        chk("t39.state", 32'(state_o), 32'd0);
        chk("t39.data_cnt", 32'(data_cnt_o), 32'd0);
        chk("t39.valid", 32'(rec_valid_o), 32'd0);
        step("idle_err", 0, 0, 1, 1, 0);
        chk("idle.data_cnt", 32'(data_cnt_o), 32'd0);

        // Long armed run to wrap the timestamp, random traffic
        step("arm", 1, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            step("wrap", 1'($urandom_range(0, 1)), 0, ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)));
        end

        // Random traffic including clears and re-arms
        for (int i = 0; i < 500; i++) begin
            step("rand", 1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0));
        end

        // Reset mid-stream with records pending
        step("clr", 0, 1, 0, 0, 0);
        step("arm", 1, 0, 0, 0, 0);
        repeat (3) step("pend", 0, 0, 1, 1, 0);
        rst_ni = 1'b0;
        #1 check_reset_values("midrst");
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        step("post_idle", 0, 0, 1, 0, 1);
        step("post_arm", 1, 0, 0, 0, 0);
        step("post_err", 0, 0, 0, 1, 0);
        chk("post.rec_ts", 32'(rec_ts_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dut_err_monitor.md
DUT_ERR_MONITOR -- requirements
Module: dut_err_monitor

Interface
REQ-001 Parameter CNT_W, default 16, width of saturating error counters.
REQ-002 Parameter TS_W, default 32, width of cycle timestamp.
REQ-003 Parameter DEPTH, default 4, error-record FIFO entries, power of two, >= 2.
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_ni  in  1  asynchronous, active-low reset.
REQ-006 arm_i  in  1  level; starts monitoring when in IDLE.
REQ-007 clr_i  in  1  pulse; synchronous clear of counters, FIFO, flags; returns FSM to IDLE.
REQ-008 err_data_i  in  1  data-error pulse from the upstream checker.
REQ-009 err_state_i  in  1  state-error pulse from the upstream checker.
REQ-010 rec_valid_o  out  1  FIFO head record available.
REQ-011 rec_ready_i  in  1  consumer accepts head record.
REQ-012 rec_ts_o  out  TS_W  timestamp of head record.
REQ-013 rec_type_o  out  2  head record type, {state_err, data_err}.
REQ-014 data_cnt_o, state_cnt_o  out  CNT_W each  saturating error totals.
REQ-015 first_ts_o  out  TS_W  timestamp of first error since arm.
REQ-016 state_o  out  2  FSM state: 00 IDLE, 01 ARMED, 10 FAULT.
REQ-017 ovf_o  out  1  sticky, a record was dropped on a full FIFO.

Function
REQ-018 IDLE: timestamp held at 0, error inputs ignored; arm_i=1 -> ARMED next cycle.
REQ-019 ARMED/FAULT: timestamp increments by 1 per cycle and wraps modulo 2^TS_W.
REQ-020 ARMED: any error input high -> FAULT next cycle; first_ts_o captures the current timestamp.
REQ-021 FAULT: remains until clr_i; first_ts_o is not updated again.
REQ-022 arm_i deassertion in ARMED/FAULT has no effect.
REQ-023 clr_i has priority over every other event in the same cycle; next cycle: IDLE, counters 0, FIFO empty, ovf_o 0, timestamp 0, first_ts_o 0.
REQ-024 In ARMED/FAULT, each cycle with err_data_i|err_state_i pushes one record {ts, {err_state_i, err_data_i}}; both high gives type 2'b11 and a single record.
REQ-025 data_cnt_o increments on each err_data_i cycle, state_cnt_o on each err_state_i cycle (ARMED/FAULT only); both saturate at 2^CNT_W-1.
REQ-026 Push-to-rec_valid_o latency: one cycle (record visible the cycle after the error cycle).
REQ-027 Pop occurs when rec_valid_o & rec_ready_i at a clock edge; rec_* outputs stable while rec_valid_o=1 and rec_ready_i=0.
REQ-028 Full FIFO with push and no pop: record dropped, ovf_o set; counters still increment.
REQ-029 Full FIFO with simultaneous push and pop: both occur, no drop, ovf_o unchanged.
REQ-030 Empty FIFO with push: no pop; rec_valid_o rises next cycle.
REQ-031 Records are delivered in push order; FIFO pointers wrap modulo DEPTH.

Reset
REQ-032 rst_ni low asynchronously forces: state IDLE, timestamp 0, counters 0, first_ts_o 0, FIFO empty, rec_valid_o 0, rec_ts_o 0, rec_type_o 0, ovf_o 0.
REQ-033 Reset mid-operation discards all pending records; after release the block behaves as after power-up.

Verification
REQ-034 Reset release, arm_i=1 at cycle 0, err_data_i pulse at timestamp 10 -> state_o 10, first_ts_o=10, one record {10, 2'b01}, data_cnt_o=1.
REQ-035 Both errors high together at timestamp 5 -> single record type 2'b11, data_cnt_o=1, state_cnt_o=1.
REQ-036 rec_ready_i=0, DEPTH+1 error cycles -> DEPTH records held, ovf_o=1, data_cnt_o=DEPTH+1; then drain: records in order, rec_valid_o falls after last.
REQ-037 FIFO full, push and pop same cycle -> occupancy unchanged, ovf_o stays 0.
REQ-038 CNT_W=4, 20 err_state_i pulses -> state_cnt_o saturates at 15.
REQ-039 clr_i asserted in same cycle as an error -> no record, counters 0, state IDLE next cycle; rst_ni low mid-stream -> all outputs at reset values immediately.
